// File: rtl/bram_stream_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_pkg
// Shared definitions for the BRAM read-side streaming front end:
//   - state_t          : transfer FSM states (IDLE, RUN, DRAIN, DONE)
//   - WORD_BYTES       : bytes per BRAM word (address stride)
//   - BUF_DEPTH        : entries in the output skid buffer
//   - align_word_addr(): clears the byte-offset bits of a byte address
// -----------------------------------------------------------------------------
package bram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BUF_DEPTH  = 2;

    // Byte addresses are forced onto a word boundary; the low offset bits
    // of the caller's address carry no meaning for 32-bit BRAM words.
    function automatic logic [31:0] align_word_addr(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// -----------------------------------------------------------------------------
// stream_fifo2
// Two-entry, 32-bit FIFO used as the output buffer of bram_stream_reader.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (clears pointers, count and data)
//   push_i  : write din_i into the tail entry
//   din_i   : write data
//   pop_i   : drop the head entry (ignored when empty)
//   occ_o   : number of valid entries, 0..2
//   head_o  : data of the head entry
// The caller guarantees no push while full without a simultaneous pop.
// -----------------------------------------------------------------------------
module stream_fifo2 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [31:0] din_i,
    input  logic        pop_i,
    output logic [1:0]  occ_o,
    output logic [31:0] head_o
);
    import bram_stream_pkg::*;

    logic [31:0] mem_q [BUF_DEPTH];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  occ_q;
    logic        pop_ok;

    assign pop_ok = pop_i && (occ_q != 2'd0);
    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

    // Data entries are reset as well so the stream data output reads zero
    // immediately after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_ok})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Walks a word-aligned BRAM address range, one read per cycle, absorbs the
// 1-cycle BRAM read latency and delivers the words on a valid/ready stream.
// Ports:
//   clk, rst (async, active-low)
//   start, base_addr, word_count : transfer command, sampled in IDLE only
//   busy, done                   : status (busy in RUN/DRAIN, done pulse)
//   bram_addr, bram_en, bram_wen, bram_din, bram_dout : BRAM read port
//   m_data, m_valid, m_ready     : output stream
// -----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      bram_addr,
    output logic             bram_en,
    output logic [3:0]       bram_wen,
    output logic [31:0]      bram_din,
    input  logic [31:0]      bram_dout,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    import bram_stream_pkg::*;

    state_t           state_q, state_d;
    logic [31:0]      next_addr_q, next_addr_d;   // address of the next read
    logic [31:0]      last_addr_q, last_addr_d;   // address of the last read
    logic [CNT_W-1:0] cnt_q, cnt_d;               // reads still to issue
    logic             inflight_q;
    logic             issue;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       slots_used;

    assign bram_wen = 4'b0000;
    assign bram_din = 32'd0;

    assign m_valid    = (occ != 2'd0);
    assign pop        = m_valid && m_ready;
    assign slots_used = {1'b0, occ} + {2'b00, inflight_q};

    // The read issued this cycle shows its own address; otherwise the port
    // keeps presenting the address of the most recent read.
    assign bram_en   = issue;
    assign bram_addr = issue ? next_addr_q : last_addr_q;

    // Every read lands in the buffer one cycle later without a space check:
    // issue is only allowed while occ + inflight stays within BUF_DEPTH.
    stream_fifo2 u_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (inflight_q),
        .din_i  (bram_dout),
        .pop_i  (pop),
        .occ_o  (occ),
        .head_o (m_data)
    );

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_d     = ST_RUN;
                        next_addr_d = align_word_addr(base_addr);
                        cnt_d       = word_count;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                busy = 1'b1;
                // A pop this cycle frees a slot, so a full pipeline can
                // still issue and keep one word per cycle.
                issue = (slots_used < 3'd2) || pop;
                if (issue) begin
                    last_addr_d = next_addr_q;
                    next_addr_d = next_addr_q + 32'(WORD_BYTES);
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                busy = 1'b1;
                if (!inflight_q &&
                    ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            next_addr_q <= '0;
            last_addr_q <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            last_addr_q <= last_addr_d;
            cnt_q       <= cnt_d;
            inflight_q  <= issue;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Directed bench for bram_stream_reader. Cycle c of a transfer starts at the
// c-th rising edge after the command was presented; inputs change 1 ns after
// that edge and outputs are observed 2 ns after it.
// BRAM contents: word at byte address a is 32'hDA7A_0000 | a[15:0].
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [31:0] bram_addr;
    logic        bram_en;
    logic [3:0]  bram_wen;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    int errors = 0;
    int checks = 0;

    bram_stream_reader #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_wen   (bram_wen),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        return 32'hDA7A_0000 | {16'h0000, a[15:0]};
    endfunction

    // BRAM with one cycle of read latency; output holds when not enabled.
    initial bram_dout = 32'd0;
    always @(posedge clk) begin
        if (bram_en) bram_dout <= bram_word(bram_addr);
    end

    task automatic begin_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; base_addr = 32'd0; word_count = 16'd0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({busy, done, bram_en, m_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/en/valid=%b required 0000",
                     {busy, done, bram_en, m_valid});
        end
        checks++;
        if ({bram_addr, m_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h data=%h required 0/0", bram_addr, m_data);
        end
        checks++;
        if ({bram_wen, bram_din} !== 36'd0) begin
            errors++;
            $display("FAIL reset_wr_port: wen=%b din=%h required 0/0", bram_wen, bram_din);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_a;
        int done_cyc = -1;
        int done_n = 0;
        for (int c = 0; c < 10; c++) begin
            begin_cycle();
            start = (c == 0); base_addr = 32'h100; word_count = 16'd4; m_ready = 1'b1;
            #1;
            if (c >= 1 && c <= 4) begin
                exp_a = 32'h100 + 32'(4 * (c - 1));
                checks++;
                if ({bram_en, bram_addr} !== {1'b1, exp_a}) begin
                    errors++;
                    $display("FAIL basic_issue c%0d: en=%b addr=%h required 1/%h",
                             c, bram_en, bram_addr, exp_a);
                end
            end
            if (c >= 3 && c <= 6) begin
                exp_a = 32'h100 + 32'(4 * (c - 3));
                checks++;
                if ({m_valid, m_data} !== {1'b1, bram_word(exp_a)}) begin
                    errors++;
                    $display("FAIL basic_stream c%0d: valid=%b data=%h required 1/%h",
                             c, m_valid, m_data, bram_word(exp_a));
                end
            end
            if (c == 2 && busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_busy: busy=%b required 1", busy);
            end
            if (c == 2) checks++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        checks++;
        if (done_cyc !== 7 || done_n !== 1) begin
            errors++;
            $display("FAIL basic_done: cycle=%0d count=%0d required 7/1", done_cyc, done_n);
        end
        checks++;
        if ({busy, m_valid, bram_en} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle: busy/valid/en=%b required 000", {busy, m_valid, bram_en});
        end
    endtask

    task automatic test_stall();
        logic [31:0] got[$];
        int en_early = 0;
        int en_total = 0;
        int done_cyc = -1;
        for (int c = 0; c < 18; c++) begin
            begin_cycle();
            start = (c == 0); base_addr = 32'h100; word_count = 16'd4;
            m_ready = !(c >= 3 && c <= 9);
            #1;
            if (bram_en) begin
                en_total++;
                if (c < 10) en_early++;
            end
            if (c >= 3 && c <= 10) begin
                checks++;
                if ({m_valid, m_data} !== {1'b1, 32'hDA7A_0100}) begin
                    errors++;
                    $display("FAIL stall_hold c%0d: valid=%b data=%h required 1/da7a0100",
                             c, m_valid, m_data);
                end
            end
            if (m_valid && m_ready) got.push_back(m_data);
            if (done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (en_early !== 2) begin
            errors++;
            $display("FAIL stall_ahead: reads before cycle 10=%0d required 2", en_early);
        end
        checks++;
        if (en_total !== 4) begin
            errors++;
            $display("FAIL stall_reads: total reads=%0d required 4", en_total);
        end
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL stall_count: words=%0d required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== bram_word(32'h100 + 32'(4 * i))) begin
                    errors++;
                    $display("FAIL stall_order w%0d: data=%h required %h",
                             i, got[i], bram_word(32'h100 + 32'(4 * i)));
                end
            end
        end
        checks++;
        if (done_cyc !== 14) begin
            errors++;
            $display("FAIL stall_done: cycle=%0d required 14", done_cyc);
        end
    endtask

    task automatic test_zero_count();
        int en_seen = 0;
        int valid_seen = 0;
        int done_cyc = -1;
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            start = (c == 0); base_addr = 32'h400; word_count = 16'd0; m_ready = 1'b1;
            #1;
            if (bram_en) en_seen++;
            if (m_valid) valid_seen++;
            if (done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (done_cyc !== 1) begin
            errors++;
            $display("FAIL zero_done: cycle=%0d required 1", done_cyc);
        end
        checks++;
        if (en_seen !== 0 || valid_seen !== 0) begin
            errors++;
            $display("FAIL zero_quiet: en cycles=%0d valid cycles=%0d required 0/0",
                     en_seen, valid_seen);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic [31:0] got[$];
        logic [31:0] exp_a[4];
        int done_cyc = -1;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
        for (int c = 0; c < 10; c++) begin
            begin_cycle();
            start = (c == 0); base_addr = 32'hFFFF_FFF8; word_count = 16'd4; m_ready = 1'b1;
            #1;
            if (bram_en) addrs.push_back(bram_addr);
            if (m_valid && m_ready) got.push_back(m_data);
            if (done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (addrs.size() !== 4 || got.size() !== 4) begin
            errors++;
            $display("FAIL wrap_count: reads=%0d words=%0d required 4/4", addrs.size(), got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addrs[i] !== exp_a[i] || got[i] !== bram_word(exp_a[i])) begin
                    errors++;
                    $display("FAIL wrap_w%0d: addr=%h data=%h required %h/%h",
                             i, addrs[i], got[i], exp_a[i], bram_word(exp_a[i]));
                end
            end
        end
        checks++;
        if (done_cyc !== 7) begin
            errors++;
            $display("FAIL wrap_done: cycle=%0d required 7", done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] addrs[$];
        logic [31:0] got[$];
        int done_n = 0;
        int done_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            begin_cycle();
            m_ready = 1'b1;
            if (c == 0) begin
                start = 1'b1; base_addr = 32'h100; word_count = 16'd4;
            end else if (c == 2) begin
                start = 1'b1; base_addr = 32'h200; word_count = 16'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (bram_en) addrs.push_back(bram_addr);
            if (m_valid && m_ready) got.push_back(m_data);
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        checks++;
        if (addrs.size() !== 4 || got.size() !== 4) begin
            errors++;
            $display("FAIL restart_count: reads=%0d words=%0d required 4/4", addrs.size(), got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addrs[i] !== 32'h100 + 32'(4 * i) ||
                    got[i] !== bram_word(32'h100 + 32'(4 * i))) begin
                    errors++;
                    $display("FAIL restart_w%0d: addr=%h data=%h required %h/%h", i,
                             addrs[i], got[i], 32'h100 + 32'(4 * i),
                             bram_word(32'h100 + 32'(4 * i)));
                end
            end
        end
        checks++;
        if (done_n !== 1 || done_cyc !== 7) begin
            errors++;
            $display("FAIL restart_done: count=%0d cycle=%0d required 1/7", done_n, done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] addrs[$];
        logic [31:0] got[$];
        int done_cyc = -1;
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            start = (c == 0); base_addr = 32'h100; word_count = 16'd4; m_ready = 1'b1;
            #1;
            if (m_valid && m_ready) got.push_back(m_data);
        end
        checks++;
        if (got.size() !== 2) begin
            errors++;
            $display("FAIL rstmid_pre: words before reset=%0d required 2", got.size());
        end
        begin_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, bram_en, m_valid} !== 4'b0000 || {bram_addr, m_data} !== 64'd0) begin
            errors++;
            $display("FAIL rstmid_clear: busy/done/en/valid=%b addr=%h data=%h required 0000/0/0",
                     {busy, done, bram_en, m_valid}, bram_addr, m_data);
        end
        begin_cycle();
        rst = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            begin_cycle();
            start = (c == 0); base_addr = 32'h0; word_count = 16'd2; m_ready = 1'b1;
            #1;
            if (bram_en) addrs.push_back(bram_addr);
            if (m_valid && m_ready) got.push_back(m_data);
            if (done && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (addrs.size() !== 2 || got.size() !== 2) begin
            errors++;
            $display("FAIL rstmid_count: reads=%0d words=%0d required 2/2", addrs.size(), got.size());
        end else begin
            checks++;
            if (addrs[0] !== 32'h0 || addrs[1] !== 32'h4) begin
                errors++;
                $display("FAIL rstmid_addr: %h %h required 00000000 00000004", addrs[0], addrs[1]);
            end
            checks++;
            if (got[0] !== 32'hDA7A_0000 || got[1] !== 32'hDA7A_0004) begin
                errors++;
                $display("FAIL rstmid_data: %h %h required da7a0000 da7a0004", got[0], got[1]);
            end
        end
        checks++;
        if (done_cyc !== 5) begin
            errors++;
            $display("FAIL rstmid_done: cycle=%0d required 5", done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_count();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
